vnarrow_pack: RTL and testbench
===============================

# vnarrow_pack

Narrowing pack stage for the vALU result path: the inverse of the widening unpack at the operand side. It accepts 64-bit beats of double-width (2·SEW) elements, truncates or saturates each element to SEW, and packs two consecutive beats (turn 0 = lower half, turn 1 = upper half) into one 64-bit destination word with compressed byte enables. It sits between the wide arithmetic lanes and the register-file write port for vn* instructions.

## Interface

Parameters:
- DATA_WIDTH, 64, beat and output word width (only 64 supported)
- SEW_WIDTH, 2, SEW encoding width (0=8b, 1=16b, 2=32b, 3=64b)
- BYTE_EN_WIDTH, 8, byte enables per word

Ports:
- clk  in  1  clock; one clock domain; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid; no backpressure
- in_vec  in  DATA_WIDTH  wide elements, each 2·SEW bits
- in_be  in  BYTE_EN_WIDTH  byte enables of the wide beat
- in_sew  in  SEW_WIDTH  destination (narrow) SEW
- in_turn  in  1  0 = beat fills lower 32 bits, 1 = upper 32 bits
- in_signed  in  1  signed narrowing (used only for saturation)
- in_last  in  1  final beat of the instruction; forces flush
- out_valid  out  1  packed word valid, single-cycle pulse
- out_vec  out  DATA_WIDTH  packed narrow elements
- out_be  out  BYTE_EN_WIDTH  packed byte enables
- out_sew  out  SEW_WIDTH  SEW of out_vec (= captured in_sew)
- out_vxsat  out  1  present only with VNARROW_SAT_EN; see Configuration

## Operation

- Narrowing per element k: keep low SEW bits of wide element k (4 elements at SEW8, 2 at SEW16, 1 at SEW32) and place them contiguously in a 32-bit half.
- Byte enable compression: narrow be bit j = in_be[2j] & in_be[2j+1], j = 0..3.
- in_sew = 3 is illegal: the beat is dropped, no state change, no output.
- State machine, states EMPTY and HALF; holding register lo_vec[31:0], lo_be[3:0], lo_sew.
  - EMPTY, valid, turn 0, !in_last: capture narrowed half into lo_*, go HALF.
  - EMPTY, valid, turn 0, in_last: emit {32'b0, half}, be {4'b0, nbe}; stay EMPTY.
  - EMPTY, valid, turn 1: emit {half, 32'b0}, be {nbe, 4'b0}; stay EMPTY.
  - HALF, valid, turn 1, in_sew == lo_sew: emit {half, lo_vec}, be {nbe, lo_be}; go EMPTY.
  - HALF, valid, turn 0 (or turn 1 with in_sew != lo_sew): emit held lo_* alone (upper be 0), then treat the new beat as from EMPTY. If it is a turn-1 beat, it is emitted on the following cycle from a one-entry skid register; a further valid beat in that cycle is a protocol violation (undefined).
  - HALF, !in_valid: hold indefinitely.
- Zero bytes are driven wherever the corresponding out_be bit is 0.

## Timing

- Reset: state EMPTY; out_valid 0, out_vec 0, out_be 0, out_sew 0, out_vxsat 0, lo_* 0, skid empty.
- Latency: out_valid asserts exactly one cycle after the clock edge that samples the completing beat; outputs are registered.
- Throughput: one packed word per two beats; one word per beat for single-half emits.
- out_vec/out_be/out_sew hold their values while out_valid is 0; only out_valid pulses.
- rst_n asserted mid-operation discards the held half and skid entry with no output.

## Configuration

- VNARROW_SAT_EN defined: each element is clamped to the destination range (signed: [-2^(SEW-1), 2^(SEW-1)-1]; unsigned: [0, 2^SEW-1]) before packing; out_vxsat is a port that pulses with out_valid when any enabled element of that word clamped.
- Undefined: plain truncation, in_signed ignored, out_vxsat port absent.

## Test plan

- SEW8, in_be=8'hFF: turn 0 in_vec=64'h0004_0003_0002_0001, then turn 1 64'h0008_0007_0006_0005 -> one cycle later out_valid=1, out_vec=64'h0807060504030201, out_be=8'hFF, out_sew=0.
- SEW16, turn 0 with in_last=1, in_vec=64'h0000_BEEF_0000_CAFE, in_be=8'h0F -> out_vec=64'h0000_0000_0000_CAFE, out_be=8'h03.
- SEW32: turn 0 64'h1_2222_2222 then turn 0 again 64'h3_4444_4444 -> first emit 64'h0000_0000_2222_2222 be 8'h0F; state HALF holding 32'h4444_4444.
- SEW16 signed, wide elements 32'h0001_0000 and 32'hFFFF_0000: with VNARROW_SAT_EN -> halves 16'h7FFF/16'h8000, out_vxsat=1; without -> 16'h0000/16'h0000.
- Turn 0 accepted, rst_n pulsed low, then turn 1 64'h0008_0007_0006_0005 SEW8 -> emit 64'h0807_0605_0000_0000, be 8'hF0; all outputs 0 during reset.

Source files
------------

// File: rtl/vnarrow_pack.sv
// vnarrow_pack: narrows 2*SEW beats to SEW and packs turn 0/1 halves into one 64-bit word.
// Define VNARROW_SAT_EN to clamp elements to the destination range and expose out_vxsat.
module vnarrow_pack #(
  parameter int DATA_WIDTH    = 64,
  parameter int SEW_WIDTH     = 2,
  parameter int BYTE_EN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_vec,
  input  logic [BYTE_EN_WIDTH-1:0] in_be,
  input  logic [SEW_WIDTH-1:0]     in_sew,
  input  logic                     in_turn,
  input  logic                     in_signed,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_vec,
  output logic [BYTE_EN_WIDTH-1:0] out_be,
  output logic [SEW_WIDTH-1:0]     out_sew
`ifdef VNARROW_SAT_EN
  ,
  output logic                     out_vxsat
`endif
);
  localparam int HW = DATA_WIDTH / 2;
  localparam int HB = BYTE_EN_WIDTH / 2;
  typedef enum logic {EMPTY, HALF} state_t;
`ifdef VNARROW_SAT_EN
  // Returns {clamped, value}; e is a zero-extended 2n-bit element.
  function automatic logic [32:0] nar(input logic [63:0] e, input int n, input logic s);
    logic [63:0] top;
    logic [31:0] mask;
    mask = 32'((64'd1 << n) - 64'd1);
    top = e >> (n - 1);
    if (s && top != 64'd0 && top != (64'd1 << (n + 1)) - 64'd1)
      return {1'b1, (|(top >> n)) ? 32'(64'd1 << (n - 1)) : 32'((64'd1 << (n - 1)) - 64'd1)};
    if (!s && (e >> n) != 64'd0)
      return {1'b1, mask};
    return {1'b0, 32'(e) & mask};
  endfunction
`else
  function automatic logic [32:0] nar(input logic [63:0] e, input int n, input logic s);
    logic unused_s;
    unused_s = s;
    return {1'b0, 32'(e & ((64'd1 << n) - 64'd1))};
  endfunction
`endif
  state_t state_q, state_d;
  logic [HW-1:0] lo_vec_q, lo_vec_d, half, h8, h16, h32, raw;
  logic [HB-1:0] lo_be_q, lo_be_d, nbe, s8;
  logic [SEW_WIDTH-1:0] lo_sew_q, lo_sew_d, skid_sew_q, skid_sew_d, out_sew_q, out_sew_d, e_sew;
  logic lo_sat_q, lo_sat_d, skid_sat_q, skid_sat_d, skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_vec_q, skid_vec_d, out_vec_q, out_vec_d, e_vec, n_vec;
  logic [BYTE_EN_WIDTH-1:0] skid_be_q, skid_be_d, out_be_q, out_be_d, e_be, n_be;
  logic out_valid_q, out_valid_d, out_vxsat_q, out_vxsat_d;
  logic [1:0] s16;
  logic [32:0] r;
  logic s32, hsat, beat_ok, new_emit, e_v, e_sat;
  always_comb begin
    r = '0;
    h8 = '0;
    h16 = '0;
    s8 = '0;
    s16 = '0;
    for (int j = 0; j < HB; j++) nbe[j] = in_be[2*j] & in_be[2*j+1];
    for (int k = 0; k < 4; k++) begin
      r = nar(64'(in_vec[16*k +: 16]), 8, in_signed);
      h8[8*k +: 8] = r[7:0];
      s8[k] = r[32] & nbe[k];
    end
    for (int k = 0; k < 2; k++) begin
      r = nar(64'(in_vec[32*k +: 32]), 16, in_signed);
      h16[16*k +: 16] = r[15:0];
      s16[k] = r[32] & |nbe[2*k +: 2];
    end
    r = nar(in_vec, 32, in_signed);
    h32 = r[31:0];
    s32 = r[32] & |nbe;
    raw = in_sew == 2'd0 ? h8 : in_sew == 2'd1 ? h16 : h32;
    hsat = in_sew == 2'd0 ? |s8 : in_sew == 2'd1 ? |s16 : s32;
    for (int j = 0; j < HB; j++) half[8*j +: 8] = raw[8*j +: 8] & {8{nbe[j]}};
  end
  always_comb begin
    beat_ok = in_valid && in_sew != 2'd3;
    new_emit = in_turn || in_last;
    n_vec = in_turn ? {half, {HW{1'b0}}} : {{HW{1'b0}}, half};
    n_be = in_turn ? {nbe, {HB{1'b0}}} : {{HB{1'b0}}, nbe};
    state_d = state_q;
    lo_vec_d = lo_vec_q;
    lo_be_d = lo_be_q;
    lo_sew_d = lo_sew_q;
    lo_sat_d = lo_sat_q;
    skid_v_d = 1'b0;
    skid_vec_d = skid_vec_q;
    skid_be_d = skid_be_q;
    skid_sew_d = skid_sew_q;
    skid_sat_d = skid_sat_q;
    e_v = skid_v_q;
    e_vec = skid_vec_q;
    e_be = skid_be_q;
    e_sew = skid_sew_q;
    e_sat = skid_sat_q;
    // A pending skid entry owns this cycle; a concurrent beat is a protocol violation.
    if (!skid_v_q && beat_ok) begin
      if (state_q == HALF && in_turn && in_sew == lo_sew_q) begin
        e_v = 1'b1;
        e_vec = {half, lo_vec_q};
        e_be = {nbe, lo_be_q};
        e_sew = in_sew;
        e_sat = hsat | lo_sat_q;
        state_d = EMPTY;
      end else begin
        e_v = state_q == HALF || new_emit;
        e_vec = state_q == HALF ? {{HW{1'b0}}, lo_vec_q} : n_vec;
        e_be = state_q == HALF ? {{HB{1'b0}}, lo_be_q} : n_be;
        e_sew = state_q == HALF ? lo_sew_q : in_sew;
        e_sat = state_q == HALF ? lo_sat_q : hsat;
        skid_v_d = state_q == HALF && new_emit;
        skid_vec_d = n_vec;
        skid_be_d = n_be;
        skid_sew_d = in_sew;
        skid_sat_d = hsat;
        lo_vec_d = new_emit ? lo_vec_q : half;
        lo_be_d = new_emit ? lo_be_q : nbe;
        lo_sew_d = new_emit ? lo_sew_q : in_sew;
        lo_sat_d = new_emit ? lo_sat_q : hsat;
        state_d = new_emit ? EMPTY : HALF;
      end
    end
    out_valid_d = e_v;
    out_vec_d = e_v ? e_vec : out_vec_q;
    out_be_d = e_v ? e_be : out_be_q;
    out_sew_d = e_v ? e_sew : out_sew_q;
    out_vxsat_d = e_v & e_sat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      lo_vec_q <= '0;
      lo_be_q <= '0;
      lo_sew_q <= '0;
      lo_sat_q <= 1'b0;
      skid_v_q <= 1'b0;
      skid_vec_q <= '0;
      skid_be_q <= '0;
      skid_sew_q <= '0;
      skid_sat_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q <= '0;
      out_be_q <= '0;
      out_sew_q <= '0;
      out_vxsat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_vec_q <= lo_vec_d;
      lo_be_q <= lo_be_d;
      lo_sew_q <= lo_sew_d;
      lo_sat_q <= lo_sat_d;
      skid_v_q <= skid_v_d;
      skid_vec_q <= skid_vec_d;
      skid_be_q <= skid_be_d;
      skid_sew_q <= skid_sew_d;
      skid_sat_q <= skid_sat_d;
      out_valid_q <= out_valid_d;
      out_vec_q <= out_vec_d;
      out_be_q <= out_be_d;
      out_sew_q <= out_sew_d;
      out_vxsat_q <= out_vxsat_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_vec = out_vec_q;
  assign out_be = out_be_q;
  assign out_sew = out_sew_q;
`ifdef VNARROW_SAT_EN
  assign out_vxsat = out_vxsat_q;
`else
  logic unused_vxsat;
  assign unused_vxsat = out_vxsat_q;
`endif
endmodule

// File: tb/tb_vnarrow_pack.sv
// tb_vnarrow_pack: directed scoreboard bench for vnarrow_pack (both VNARROW_SAT_EN builds).
module tb_vnarrow_pack;
`ifdef VNARROW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    logic [63:0] vec;
    logic [7:0]  be;
    logic [1:0]  sew;
    logic        sat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_turn, in_signed, in_last, out_valid;
  logic [63:0] in_vec, out_vec;
  logic [7:0] in_be, out_be;
  logic [1:0] in_sew, out_sew;
`ifdef VNARROW_SAT_EN
  logic out_vxsat;
`endif
  exp_t q[$];
  exp_t last;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  vnarrow_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec), .in_be(in_be),
    .in_sew(in_sew), .in_turn(in_turn), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_vec(out_vec), .out_be(out_be), .out_sew(out_sew)
`ifdef VNARROW_SAT_EN
    , .out_vxsat(out_vxsat)
`endif
  );
  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic zero_chk(input string tag);
    cmp({tag, "_valid"}, 64'(out_valid), 64'd0);
    cmp({tag, "_vec"}, out_vec, 64'd0);
    cmp({tag, "_be"}, 64'(out_be), 64'd0);
    cmp({tag, "_sew"}, 64'(out_sew), 64'd0);
`ifdef VNARROW_SAT_EN
    cmp({tag, "_vxsat"}, 64'(out_vxsat), 64'd0);
`endif
  endtask
  task automatic check();
    exp_t e;
    cmp("valid", 64'(out_valid), 64'(q.size() > 0));
    if (out_valid && q.size() > 0) begin
      e = q.pop_front();
      last = e;
      cmp("vec", out_vec, e.vec);
      cmp("be", 64'(out_be), 64'(e.be));
      cmp("sew", 64'(out_sew), 64'(e.sew));
`ifdef VNARROW_SAT_EN
      cmp("vxsat", 64'(out_vxsat), 64'(e.sat));
`endif
    end else if (!out_valid) begin
      cmp("hold_vec", out_vec, last.vec);
      cmp("hold_be", 64'(out_be), 64'(last.be));
      cmp("hold_sew", 64'(out_sew), 64'(last.sew));
`ifdef VNARROW_SAT_EN
      cmp("idle_vxsat", 64'(out_vxsat), 64'd0);
`endif
    end
  endtask
  task automatic push(input logic [63:0] v, input logic [7:0] b, input logic [1:0] s, input logic t);
    q.push_back({v, b, s, t});
  endtask
  task automatic beat(input logic [63:0] v, input logic [7:0] b, input logic [1:0] s,
                      input logic t, input logic sg, input logic l);
    in_valid = 1'b1;
    in_vec = v;
    in_be = b;
    in_sew = s;
    in_turn = t;
    in_signed = sg;
    in_last = l;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check();
  endtask
  task automatic idle();
    @(posedge clk);
    @(negedge clk);
    check();
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_vec = '0;
    in_be = '0;
    in_sew = '0;
    in_turn = 1'b0;
    in_signed = 1'b0;
    in_last = 1'b0;
    last = '0;
    repeat (2) @(negedge clk);
    zero_chk("reset");
    rst_n = 1'b1;
    idle();
    beat(64'h0004_0003_0002_0001, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
    push(64'h0807_0605_0403_0201, 8'hFF, 2'd0, 1'b0);
    beat(64'h0008_0007_0006_0005, 8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    push(64'h0000_0000_0000_CAFE, 8'h03, 2'd1, 1'b0);
    beat(64'h0000_BEEF_0000_CAFE, 8'h0F, 2'd1, 1'b0, 1'b0, 1'b1);
    beat(64'h1_2222_2222, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b0);
    push(SAT ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_2222_2222, 8'h0F, 2'd2, SAT);
    beat(64'h3_4444_4444, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    push(SAT ? 64'h5555_5555_FFFF_FFFF : 64'h5555_5555_4444_4444, 8'hFF, 2'd2, SAT);
    beat(64'h0000_0000_5555_5555, 8'hFF, 2'd2, 1'b1, 1'b0, 1'b0);
    beat(64'h0044_0033_0022_0011, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
    push(64'h0000_0000_4433_2211, 8'h0F, 2'd0, 1'b0);
    push(64'hBBBB_AAAA_0000_0000, 8'hF0, 2'd1, 1'b0);
    beat(64'h0000_BBBB_0000_AAAA, 8'hFF, 2'd1, 1'b1, 1'b0, 1'b0);
    idle();
    beat(64'h0000_1234_0000_5678, 8'hFF, 2'd1, 1'b0, 1'b0, 1'b0);
    push(64'h0000_0000_1234_5678, 8'h0F, 2'd1, 1'b0);
    push(64'h0000_0000_00AA_00BB, 8'h05, 2'd1, 1'b0);
    beat(64'h0000_77AA_0000_66BB, 8'h33, 2'd1, 1'b0, 1'b0, 1'b1);
    idle();
    push(SAT ? 64'h0000_0000_8000_7FFF : 64'h0, 8'h0F, 2'd1, SAT);
    beat({32'hFFFF_0000, 32'h0001_0000}, 8'hFF, 2'd1, 1'b0, 1'b1, 1'b1);
    push(SAT ? 64'hFFFF_8012_0000_0000 : 64'h00FF_8012_0000_0000, 8'hF0, 2'd0, SAT);
    beat(64'h0100_00FF_0080_0012, 8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(64'h1111_2222_3333_4444, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b1);
    beat(64'h0004_0003_0002_0001, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
    beat(64'h1111_2222_3333_4444, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0);
    push(64'h0807_0605_0403_0201, 8'hFF, 2'd0, 1'b0);
    beat(64'h0008_0007_0006_0005, 8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(64'h00AA_00BB_00CC_00DD, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 zero_chk("midreset");
    @(negedge clk);
    zero_chk("midreset_hold");
    rst_n = 1'b1;
    last = '0;
    idle();
    push(64'h0807_0605_0000_0000, 8'hF0, 2'd0, 1'b0);
    beat(64'h0008_0007_0006_0005, 8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    cmp("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
